// File: rtl/led_display_pkg.sv
// -----------------------------------------------------------------------------
// led_display_pkg
// Shared definitions for the LED display PWM array:
//   - legal parameter ranges for DEPTH and NUM_CHANNELS
//   - run_state_t : idle/run state of the period sequencer
//   - calc_divisor : clocks per PWM tick, floored and clamped to at least 1
//   - phase_offset : per-channel phase stagger, in ticks
// -----------------------------------------------------------------------------
package led_display_pkg;

    localparam int DEPTH_MIN        = 2;
    localparam int DEPTH_MAX        = 12;
    localparam int NUM_CHANNELS_MIN = 1;
    localparam int NUM_CHANNELS_MAX = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // One PWM period is (2^depth - 1) ticks. The divisor spreads those ticks
    // over one period of pwm_freq. A zero result from a fast PWM request is
    // clamped to 1, so the array then simply runs at one tick per clock.
    function automatic int calc_divisor(longint sys_clk_freq, longint pwm_freq, int depth);
        longint steps;
        longint div;
        steps = (longint'(1) << depth) - 1;
        div   = sys_clk_freq / (pwm_freq * steps);
        return (div < 1) ? 1 : int'(div);
    endfunction

    // Channel i starts its period i*floor(period/num_channels) ticks early.
    // This spreads the rising edges evenly and reduces supply current peaks.
    function automatic int phase_offset(int channel, int depth, int num_channels);
        return channel * (((1 << depth) - 1) / num_channels);
    endfunction

endpackage

// File: rtl/led_display_pwm_prescaler.sv
// -----------------------------------------------------------------------------
// led_display_pwm_prescaler
// Produces a one-clock tick every `divisor` clocks while enabled. The count
// is held at 0 while disabled, so the first tick after enabling comes
// exactly `divisor` clocks later.
// Ports:
//   clk_in      : clock, rising edge
//   n_reset_in  : asynchronous active-low reset
//   enable_in   : run control; low holds the count at 0
//   divisor     : clocks per tick, must be >= 1
//   tick        : one-clock pulse on the last clock of each divisor window
// -----------------------------------------------------------------------------
module led_display_pwm_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic             enable_in,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic             at_end;

    assign at_end = (count_q == (divisor - DIV_W'(1)));
    assign tick   = enable_in && at_end;

    // NOTE: State registers use non-blocking (<=) assignments. All flops then
    // update together at the clock edge, and the result does not depend on
    // the order in which the simulator runs the always blocks.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            count_q <= '0;
        end else if (!enable_in || at_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_display_pwm_array.sv
// -----------------------------------------------------------------------------
// led_display_pwm_array
// An array of NUM_CHANNELS PWM outputs that share one period counter.
// Duties are written into shadow registers at any time. They are copied to
// the active registers only at a period boundary, or when the array is
// enabled, so a period is never cut in a glitchy way.
// Ports:
//   clk_in           : clock, rising edge
//   n_reset_in       : asynchronous active-low reset
//   enable_in        : run control; low idles the array with outputs inactive
//   wr_en_in         : duty write strobe
//   wr_addr_in       : channel index for the write; out-of-range is ignored
//   wr_data_in       : duty value, 0 = always off, 2^DEPTH-1 = always on
//   pwm_out          : registered PWM outputs, inverted when ACTIVE_LOW=1
//   period_start_out : one-clock pulse in the first output clock of count 0
// -----------------------------------------------------------------------------
module led_display_pwm_array
    import led_display_pkg::*;
#(
    parameter  int SYS_CLK_FREQ = 12_500_000,
    parameter  int PWM_FREQ     = 1_000,
    parameter  int NUM_CHANNELS = 6,
    parameter  int DEPTH        = 8,
    parameter  int PHASE_SPREAD = 0,
    parameter  int ACTIVE_LOW   = 0,
    localparam int ADDR_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk_in,
    input  logic                    n_reset_in,
    input  logic                    enable_in,
    input  logic                    wr_en_in,
    input  logic [ADDR_W-1:0]       wr_addr_in,
    input  logic [DEPTH-1:0]        wr_data_in,
    output logic [NUM_CHANNELS-1:0] pwm_out,
    output logic                    period_start_out
);

    localparam int PERIOD  = (1 << DEPTH) - 1;
    localparam int DIVISOR = calc_divisor(SYS_CLK_FREQ, PWM_FREQ, DEPTH);
    localparam int DIV_W   = $clog2(DIVISOR + 1);

    localparam logic [DEPTH-1:0]        COUNT_MAX = DEPTH'(PERIOD - 1);
    localparam logic [NUM_CHANNELS-1:0] INACTIVE  = {NUM_CHANNELS{(ACTIVE_LOW != 0)}};

    // ---------------------------------------------------------------------
    // Parameter legality, checked at elaboration
    // ---------------------------------------------------------------------
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("led_display_pwm_array: DEPTH must be within 2..12");
    end
    if (NUM_CHANNELS < NUM_CHANNELS_MIN || NUM_CHANNELS > NUM_CHANNELS_MAX) begin : g_bad_channels
        $error("led_display_pwm_array: NUM_CHANNELS must be within 1..32");
    end
    if (PHASE_SPREAD != 0 && PHASE_SPREAD != 1) begin : g_bad_spread
        $error("led_display_pwm_array: PHASE_SPREAD must be 0 or 1");
    end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_polarity
        $error("led_display_pwm_array: ACTIVE_LOW must be 0 or 1");
    end
    if (SYS_CLK_FREQ <= 0 || PWM_FREQ <= 0) begin : g_bad_freq
        $error("led_display_pwm_array: SYS_CLK_FREQ and PWM_FREQ must be positive");
    end

    // ---------------------------------------------------------------------
    // Idle/run sequencing
    // ---------------------------------------------------------------------
    run_state_t state_q;
    run_state_t state_d;
    logic       start;      // first enabled clock after idle: load duties, begin at 0
    logic       running;    // counting this clock
    logic       tick;
    logic       wrap;       // tick that returns the counter to 0
    logic       load;       // copy shadow duties into the active set

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: Every signal written here gets a default value first, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Enable is qualified here as well as in the state. A falling enable then
    // blanks the outputs on the very next clock instead of finishing the period.
    assign running = (state_q == ST_RUN) && enable_in;

    led_display_pwm_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .enable_in  (running),
        .divisor    (DIV_W'(DIVISOR)),
        .tick       (tick)
    );

    // ---------------------------------------------------------------------
    // Period counter: 0 .. 2^DEPTH-2, then wrap
    // ---------------------------------------------------------------------
    logic [DEPTH-1:0] count_q;
    logic             first_q;  // this is the first clock of count 0 of a period

    assign wrap = running && tick && (count_q == COUNT_MAX);
    assign load = start || wrap;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            count_q <= '0;
            first_q <= 1'b0;
        end else if (!running) begin
            count_q <= '0;
            first_q <= start;
        end else begin
            first_q <= 1'b0;
            if (tick) begin
                if (count_q == COUNT_MAX) begin
                    count_q <= '0;
                    first_q <= 1'b1;
                end else begin
                    count_q <= count_q + DEPTH'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Duty registers
    // ---------------------------------------------------------------------
    logic [DEPTH-1:0] shadow_q [NUM_CHANNELS];
    logic [DEPTH-1:0] active_q [NUM_CHANNELS];

    // NOTE: The duty arrays are small and must start at 0. The outputs are
    // defined immediately after reset, so these arrays are built from
    // resettable flops and not from RAM.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (wr_en_in && (int'(wr_addr_in) < NUM_CHANNELS)) begin
                shadow_q[wr_addr_in] <= wr_data_in;
            end
            // The active set is loaded from the shadow value held before this
            // edge. A write on the boundary clock therefore waits one period.
            if (load) begin
                active_q <= shadow_q;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-channel compare
    // ---------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0] raw;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        localparam int OFFSET = (PHASE_SPREAD != 0) ? phase_offset(i, DEPTH, NUM_CHANNELS) : 0;

        logic [DEPTH:0]   sum;
        logic [DEPTH-1:0] phase;

        // count and offset are each below PERIOD. A single conditional
        // subtract therefore gives the modulo.
        assign sum    = {1'b0, count_q} + (DEPTH+1)'(OFFSET);
        assign phase  = (sum >= (DEPTH+1)'(PERIOD)) ? DEPTH'(sum - (DEPTH+1)'(PERIOD))
                                                    : sum[DEPTH-1:0];
        assign raw[i] = (phase < active_q[i]);
    end

    // ---------------------------------------------------------------------
    // Registered outputs, one clock behind the counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            pwm_out          <= INACTIVE;
            period_start_out <= 1'b0;
        end else begin
            pwm_out          <= running ? (raw ^ INACTIVE) : INACTIVE;
            period_start_out <= running && first_q;
        end
    end

endmodule

// File: tb/tb_led_display_pwm_array.sv
// -----------------------------------------------------------------------------
// tb_led_display_pwm_array
// Two DEPTH=4, 4-channel arrays (divisor 1) share one stimulus stream:
//   dut_a : aligned phases, active high
//   dut_b : staggered phases, active low
// A third array, dut_c, uses the default DEPTH=8 and 6 channels with a
// PWM_FREQ that clamps the divisor to 1.
// Reference models run at each posedge and queue the expected outputs.
// A monitor pops and compares them at each negedge.
// -----------------------------------------------------------------------------
module tb_led_display_pwm_array;

    localparam int DEPTH    = 4;
    localparam int NCH      = 4;
    localparam int AW       = 2;
    localparam int PERIOD   = (1 << DEPTH) - 1;   // 15 ticks
    localparam int C_NCH    = 6;
    localparam int C_PERIOD = 255;

    logic             clk_in     = 1'b0;
    logic             n_reset_in = 1'b1;
    logic             enable_in  = 1'b0;
    logic             wr_en_in   = 1'b0;
    logic [AW-1:0]    wr_addr_in = '0;
    logic [DEPTH-1:0] wr_data_in = '0;
    logic [NCH-1:0]   pwm_a, pwm_b;
    logic             ps_a, ps_b;

    logic             c_enable  = 1'b0;
    logic             c_wr_en   = 1'b0;
    logic [2:0]       c_wr_addr = '0;
    logic [7:0]       c_wr_data = '0;
    logic [C_NCH-1:0] pwm_c;
    logic             ps_c;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    led_display_pwm_array #(
        .SYS_CLK_FREQ(15), .PWM_FREQ(1), .NUM_CHANNELS(NCH), .DEPTH(DEPTH),
        .PHASE_SPREAD(0), .ACTIVE_LOW(0)
    ) dut_a (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(enable_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .pwm_out(pwm_a), .period_start_out(ps_a)
    );

    led_display_pwm_array #(
        .SYS_CLK_FREQ(15), .PWM_FREQ(1), .NUM_CHANNELS(NCH), .DEPTH(DEPTH),
        .PHASE_SPREAD(1), .ACTIVE_LOW(1)
    ) dut_b (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(enable_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .pwm_out(pwm_b), .period_start_out(ps_b)
    );

    led_display_pwm_array #(
        .SYS_CLK_FREQ(12_500_000), .PWM_FREQ(100_000)
    ) dut_c (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .enable_in(c_enable),
        .wr_en_in(c_wr_en), .wr_addr_in(c_wr_addr), .wr_data_in(c_wr_data),
        .pwm_out(pwm_c), .period_start_out(ps_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A channel is on while its phase within the period is below its duty.
    function automatic logic pwm_bit(int cnt, int off, int period, int duty);
        return ((cnt + off) % period) < duty;
    endfunction

    // ------------------------------------------------------------------
    // Reference models. k counts the clocks since the array started
    // running, so the current period position is simply k mod period.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [NCH-1:0] pwm_a;
        logic [NCH-1:0] pwm_b;
        logic           ps;
    } exp_t;

    typedef struct packed {
        logic [C_NCH-1:0] pwm;
        logic             ps;
    } exp_c_t;

    exp_t   sb_q[$];
    exp_c_t sbc_q[$];

    int m_shadow[NCH];
    int m_active[NCH];
    int m_k = -1;
    int c_shadow[C_NCH];
    int c_active[C_NCH];
    int c_k = -1;

    always @(posedge clk_in) begin : model_ab
        exp_t e;
        int   cnt;
        e.pwm_a = '0;
        e.pwm_b = '1;
        e.ps    = 1'b0;
        if (!n_reset_in) begin
            foreach (m_shadow[i]) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_k = -1;
        end else begin
            if (!enable_in) begin
                m_k = -1;
            end else if (m_k < 0) begin
                m_active = m_shadow;
                m_k      = 0;
            end else begin
                cnt  = m_k % PERIOD;
                e.ps = (cnt == 0);
                for (int i = 0; i < NCH; i++) begin
                    e.pwm_a[i] = pwm_bit(cnt, 0, PERIOD, m_active[i]);
                    e.pwm_b[i] = !pwm_bit(cnt, i * (PERIOD / NCH), PERIOD, m_active[i]);
                end
                m_k++;
                if (m_k % PERIOD == 0) m_active = m_shadow;
            end
            if (wr_en_in && wr_addr_in < NCH) m_shadow[wr_addr_in] = int'(wr_data_in);
        end
        sb_q.push_back(e);
    end

    always @(posedge clk_in) begin : model_c
        exp_c_t e;
        int     cnt;
        e.pwm = '0;
        e.ps  = 1'b0;
        if (!n_reset_in) begin
            foreach (c_shadow[i]) begin
                c_shadow[i] = 0;
                c_active[i] = 0;
            end
            c_k = -1;
        end else begin
            if (!c_enable) begin
                c_k = -1;
            end else if (c_k < 0) begin
                c_active = c_shadow;
                c_k      = 0;
            end else begin
                cnt  = c_k % C_PERIOD;
                e.ps = (cnt == 0);
                for (int i = 0; i < C_NCH; i++) e.pwm[i] = pwm_bit(cnt, 0, C_PERIOD, c_active[i]);
                c_k++;
                if (c_k % C_PERIOD == 0) c_active = c_shadow;
            end
            if (c_wr_en && c_wr_addr < C_NCH) c_shadow[c_wr_addr] = int'(c_wr_data);
        end
        sbc_q.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor. Reset is asynchronous, so while it is low the outputs must
    // already show reset values, whatever the last edge queued.
    // ------------------------------------------------------------------
    int c_cycle = 0;
    int c_last  = -1;
    int c_gaps  = 0;

    always @(negedge clk_in) begin : monitor
        exp_t   e;
        exp_c_t ec;
        c_cycle++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (!n_reset_in) begin
                e.pwm_a = '0;
                e.pwm_b = '1;
                e.ps    = 1'b0;
            end
            check("pwm_a", 32'(pwm_a), 32'(e.pwm_a));
            check("ps_a", 32'(ps_a), 32'(e.ps));
            check("pwm_b", 32'(pwm_b), 32'(e.pwm_b));
            check("ps_b", 32'(ps_b), 32'(e.ps));
        end
        if (sbc_q.size() > 0) begin
            ec = sbc_q.pop_front();
            if (!n_reset_in) begin
                ec.pwm = '0;
                ec.ps  = 1'b0;
            end
            check("pwm_c", 32'(pwm_c), 32'(ec.pwm));
            check("ps_c", 32'(ps_c), 32'(ec.ps));
        end
        if (!n_reset_in || !c_enable) begin
            c_last = -1;
        end else if (ps_c) begin
            if (c_last >= 0) begin
                check("ps_c_gap", 32'(c_cycle - c_last), 32'(C_PERIOD));
                c_gaps++;
            end
            c_last = c_cycle;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after a posedge
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en_in   = 1'b1;
        wr_addr_in = AW'(a);
        wr_data_in = DEPTH'(d);
        step();
        wr_en_in   = 1'b0;
    endtask

    task automatic c_wr(input int a, input int d);
        c_wr_en   = 1'b1;
        c_wr_addr = 3'(a);
        c_wr_data = 8'(d);
        step();
        c_wr_en   = 1'b0;
    endtask

    // Wait until the counter of dut_a/dut_b holds count c during the
    // current clock.
    task automatic wait_count(input int c);
        int guard = 0;
        while (!(m_k >= 0 && (m_k % PERIOD) == c)) begin
            step();
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_count: count %0d not reached within 200 cycles", c);
                return;
            end
        end
    endtask

    initial begin
        #1 n_reset_in = 1'b0;
        step(3);
        n_reset_in = 1'b1;
        step();

        check("div_default", 32'(led_display_pkg::calc_divisor(12_500_000, 1_000, 8)), 32'd49);
        check("div_clamp", 32'(led_display_pkg::calc_divisor(12_500_000, 100_000, 8)), 32'd1);

        // dut_c: addresses 6 and 7 are out of range. Channels 5 and 1 go full on.
        c_wr(6, 255);
        c_wr(7, 255);
        c_wr(5, 255);
        c_wr(1, 255);
        c_enable = 1'b1;

        // Widths 0, 5, 15 and 7 from a common start
        wr(0, 0); wr(1, 5); wr(2, 15); wr(3, 7);
        enable_in = 1'b1;
        step(3 * PERIOD + 2);

        // Mid-period rewrite is held off until the next boundary
        wr(0, 3);
        wait_count(5);
        wr(0, 10);
        step(2 * PERIOD);

        // A write on the boundary clock lands one period later
        wait_count(PERIOD - 1);
        wr(1, 9);
        step(2 * PERIOD + 3);

        // Staggered phases with equal duties
        wr(0, 3); wr(1, 3); wr(2, 3); wr(3, 3);
        step(2 * PERIOD + 4);

        // Drop enable mid-period, then re-enable
        wait_count(7);
        enable_in = 1'b0;
        wr(2, 12);
        step(3);
        enable_in = 1'b1;
        step(2 * PERIOD);

        // Reset mid-period, then restart with all duties zero
        wait_count(7);
        n_reset_in = 1'b0;
        step(3);
        n_reset_in = 1'b1;
        step(2 * PERIOD + 3);
        c_wr(5, 255);
        c_wr(0, 255);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            wr_en_in   = ($urandom_range(0, 3) == 0);
            wr_addr_in = AW'($urandom_range(0, NCH - 1));
            wr_data_in = ($urandom_range(0, 4) == 0) ? DEPTH'(PERIOD) : DEPTH'($urandom_range(0, PERIOD));
            c_wr_en    = ($urandom_range(0, 20) == 0);
            c_wr_addr  = 3'($urandom_range(0, 7));
            c_wr_data  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
            if (!n_reset_in) begin
                n_reset_in = 1'b1;
            end else if ($urandom_range(0, 700) == 0) begin
                n_reset_in = 1'b0;
            end
            if (enable_in && $urandom_range(0, 200) == 0) begin
                enable_in = 1'b0;
            end else if (!enable_in && $urandom_range(0, 5) == 0) begin
                enable_in = 1'b1;
            end
            step();
        end

        // Quiet run so that dut_c shows several full periods
        wr_en_in   = 1'b0;
        c_wr_en    = 1'b0;
        n_reset_in = 1'b1;
        enable_in  = 1'b1;
        step(3 * C_PERIOD + 20);

        check("ps_c_gaps_seen", 32'(c_gaps >= 2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
